cksum_dispatch: RTL

CKSUM_DISPATCH -- requirements
Module: cksum_dispatch

---
 rtl/cksum_dispatch_pkg.sv | 31 +++
 rtl/cksum_desc_table.sv | 52 +++++
 rtl/cksum_dispatch.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cksum_dispatch_pkg.sv
// Shared definitions for the checksum dispatcher.
//   ADDR_BUS / DATA_BUS : operand bus widths
//   disp_state_e        : dispatcher FSM encodings (CKSUM_DISP_STATE_*)
//   desc_t              : one checksum descriptor
//   idx_w()             : index width for a table of n entries (min 1)
package cksum_dispatch_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;

  typedef enum logic [2:0] {
    CKSUM_DISP_STATE_IDLE    = 3'd0,
    CKSUM_DISP_STATE_SCAN    = 3'd1,
    CKSUM_DISP_STATE_ISSUE   = 3'd2,
    CKSUM_DISP_STATE_WAIT    = 3'd3,
    CKSUM_DISP_STATE_RELEASE = 3'd4,
    CKSUM_DISP_STATE_FINISH  = 3'd5
  } disp_state_e;

  typedef struct packed {
    logic                valid;
    logic [ADDR_BUS-1:0] field_start;
    logic [DATA_BUS-1:0] field_len;
    logic [ADDR_BUS-1:0] dst_start;
  } desc_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cksum_desc_table.sv
// Checksum descriptor table: one synchronous write port, one asynchronous
// read port. Only the valid bits are reset; descriptor data is don't-care
// until written.
//   clk, rst          : clock, synchronous active-high reset
//   we_i, wr_idx_i    : write strobe and index
//   wr_desc_i         : descriptor to store
//   rd_idx_i          : read index
//   rd_desc_o         : descriptor at rd_idx_i (combinational)
module cksum_desc_table
  import cksum_dispatch_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W       = idx_w(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  desc_t            wr_desc_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output desc_t            rd_desc_o
);

  // Padded to a power of two so every index value is in range.
  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]    valid_q;
  logic [ADDR_BUS-1:0] fs_q [DEPTH];
  logic [DATA_BUS-1:0] fl_q [DEPTH];
  logic [ADDR_BUS-1:0] ds_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else if (we_i) valid_q[wr_idx_i] <= wr_desc_i.valid;
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      fs_q[wr_idx_i] <= wr_desc_i.field_start;
      fl_q[wr_idx_i] <= wr_desc_i.field_len;
      ds_q[wr_idx_i] <= wr_desc_i.dst_start;
    end
  end

  always_comb begin
    rd_desc_o.valid       = valid_q[rd_idx_i];
    rd_desc_o.field_start = fs_q[rd_idx_i];
    rd_desc_o.field_len   = fl_q[rd_idx_i];
    rd_desc_o.dst_start   = ds_q[rd_idx_i];
  end

endmodule

// File: rtl/cksum_dispatch.sv
// Checksum dispatcher: on pkt_start_i walks the descriptor table in
// ascending order and runs one checksum engine operation per valid entry,
// holding operands stable for the whole operation and bounding each wait.
//   clk, rst                       : clock, synchronous active-high reset
//   cfg_we_i/cfg_idx_i/cfg_valid_i : descriptor write (accepted only when idle)
//   cfg_field_start_i/len/dst      : descriptor contents
//   cfg_ack_o                      : pulse, write accepted
//   pkt_start_i                    : pulse, start a checksum pass
//   busy_o, done_o, timeout_o      : pass status
//   cksum_start_o, cksum_*_o       : engine request level and operands
//   cksum_ready_i                  : engine completion level
module cksum_dispatch
  import cksum_dispatch_pkg::*;
#(
  parameter int NUM_ENTRIES    = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_we_i,
  input  logic [idx_w(NUM_ENTRIES)-1:0]     cfg_idx_i,
  input  logic                              cfg_valid_i,
  input  logic [ADDR_BUS-1:0]               cfg_field_start_i,
  input  logic [DATA_BUS-1:0]               cfg_field_len_i,
  input  logic [ADDR_BUS-1:0]               cfg_dst_start_i,
  output logic                              cfg_ack_o,
  input  logic                              pkt_start_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              timeout_o,
  output logic                              cksum_start_o,
  output logic [ADDR_BUS-1:0]               cksum_field_start_o,
  output logic [DATA_BUS-1:0]               cksum_field_len_o,
  output logic [ADDR_BUS-1:0]               cksum_dst_start_o,
  input  logic                              cksum_ready_i
);

  localparam int IDX_W = idx_w(NUM_ENTRIES);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // idx carries one extra bit so it can reach NUM_ENTRIES (end of scan).
  localparam logic [IDX_W:0]   IDX_END = (IDX_W+1)'(NUM_ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  disp_state_e         state_q, state_d;
  logic [IDX_W:0]      idx_q, idx_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d, wcnt_inc;
  logic                timeout_q, timeout_d;
  logic                start_q, start_d;
  logic                ack_q;
  logic [ADDR_BUS-1:0] fs_q, fs_d;
  logic [DATA_BUS-1:0] fl_q, fl_d;
  logic [ADDR_BUS-1:0] ds_q, ds_d;

  logic  busy;
  logic  cfg_wr;
  logic  scan_end;
  logic  wait_expired;
  desc_t wr_desc, rd_desc;

  assign busy     = (state_q == CKSUM_DISP_STATE_SCAN)  ||
                    (state_q == CKSUM_DISP_STATE_ISSUE) ||
                    (state_q == CKSUM_DISP_STATE_WAIT)  ||
                    (state_q == CKSUM_DISP_STATE_RELEASE);
  assign cfg_wr   = cfg_we_i && !busy;
  assign scan_end = (idx_q == IDX_END);
  assign wr_desc  = '{cfg_valid_i, cfg_field_start_i, cfg_field_len_i, cfg_dst_start_i};

  // Saturating wait counter; expiry is judged on the post-increment value
  // so exactly TIMEOUT_CYCLES WAIT cycles elapse before giving up.
  assign wcnt_inc     = (wcnt_q == CNT_MAX) ? wcnt_q : wcnt_q + 1'b1;
  assign wait_expired = (wcnt_inc == CNT_MAX);

  // A write in the same idle cycle as pkt_start_i lands before the first
  // SCAN reads the table, so the pass sees the new entry.
  cksum_desc_table #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .we_i      (cfg_wr),
    .wr_idx_i  (cfg_idx_i),
    .wr_desc_i (wr_desc),
    .rd_idx_i  (idx_q[IDX_W-1:0]),
    .rd_desc_o (rd_desc)
  );

  // State register plus datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CKSUM_DISP_STATE_IDLE;
      idx_q     <= '0;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      ack_q     <= 1'b0;
      fs_q      <= '0;
      fl_q      <= '0;
      ds_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      ack_q     <= cfg_wr;
      fs_q      <= fs_d;
      fl_q      <= fl_d;
      ds_q      <= ds_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      CKSUM_DISP_STATE_IDLE:    if (pkt_start_i) state_d = CKSUM_DISP_STATE_SCAN;
      CKSUM_DISP_STATE_SCAN: begin
        if (scan_end)           state_d = CKSUM_DISP_STATE_FINISH;
        else if (rd_desc.valid) state_d = CKSUM_DISP_STATE_ISSUE;
      end
      // ready may still be high from the previous operation; not sampled here
      CKSUM_DISP_STATE_ISSUE:   state_d = CKSUM_DISP_STATE_WAIT;
      CKSUM_DISP_STATE_WAIT:    if (cksum_ready_i || wait_expired) state_d = CKSUM_DISP_STATE_RELEASE;
      CKSUM_DISP_STATE_RELEASE: state_d = CKSUM_DISP_STATE_SCAN;
      CKSUM_DISP_STATE_FINISH:  state_d = CKSUM_DISP_STATE_IDLE;
      default:                  state_d = CKSUM_DISP_STATE_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    start_d   = start_q;
    fs_d      = fs_q;
    fl_d      = fl_q;
    ds_d      = ds_q;
    case (state_q)
      CKSUM_DISP_STATE_IDLE: begin
        if (pkt_start_i) begin
          idx_d     = '0;
          timeout_d = 1'b0;
        end
      end
      CKSUM_DISP_STATE_SCAN: begin
        if (!scan_end) begin
          if (rd_desc.valid) begin
            fs_d    = rd_desc.field_start;
            fl_d    = rd_desc.field_len;
            ds_d    = rd_desc.dst_start;
            start_d = 1'b1;
            wcnt_d  = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      CKSUM_DISP_STATE_WAIT: begin
        wcnt_d = wcnt_inc;
        if (cksum_ready_i) begin
          start_d = 1'b0;
        end else if (wait_expired) begin
          start_d   = 1'b0;
          timeout_d = 1'b1;
        end
      end
      CKSUM_DISP_STATE_RELEASE: idx_d = idx_q + 1'b1;
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o              = busy;
    done_o              = (state_q == CKSUM_DISP_STATE_FINISH);
    timeout_o           = timeout_q;
    cfg_ack_o           = ack_q;
    cksum_start_o       = start_q;
    cksum_field_start_o = fs_q;
    cksum_field_len_o   = fl_q;
    cksum_dst_start_o   = ds_q;
  end

endmodule
